// File: rtl/pmp_access_gate_pkg.sv
// Shared types and constants for the PMP access gate: FSM states, access
// operations, trap cause codes and the latched request record.
package pmp_access_gate_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } gate_state_e;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_EXEC    = 2'd2,
        OP_ILLEGAL = 2'd3
    } mem_oper_e;

    localparam logic [3:0] CAUSE_INSTR_AF = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
    localparam logic [3:0] CAUSE_LOAD_AF  = 4'd5;
    localparam logic [3:0] CAUSE_STORE_AF = 4'd7;

    localparam logic [1:0] PERM_OK = 2'b11;

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  size;
        mem_oper_e   oper;
        logic [1:0]  priv;
        logic [31:0] wdata;
    } gate_req_t;

    // Trap cause for a refused access; the illegal encoding shares this path.
    function automatic logic [3:0] fault_cause(input mem_oper_e op);
        case (op)
            OP_EXEC:  return CAUSE_INSTR_AF;
            OP_READ:  return CAUSE_LOAD_AF;
            OP_WRITE: return CAUSE_STORE_AF;
            default:  return CAUSE_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/pmp_access_gate_if.sv
// Bus bundle around the access gate: core request, pmp check, memory port,
// trap report and fault counter. slave = gate side, master = environment side.
interface pmp_access_gate_if #(
    parameter int CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_addr;
    logic [1:0]       req_size;
    logic [1:0]       req_oper;
    logic [1:0]       req_priv;
    logic [31:0]      req_wdata;

    logic [31:0]      pmp_addr;
    logic [1:0]       pmp_size;
    logic [1:0]       pmp_oper;
    logic [1:0]       pmp_priv;
    logic [1:0]       pmp_permission;

    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [1:0]       mem_size;
    logic             mem_we;
    logic [31:0]      mem_wdata;

    logic             trap_valid;
    logic [3:0]       trap_cause;
    logic [31:0]      trap_tval;
    logic             trap_ack;

    logic [CNT_W-1:0] fault_count;

    modport slave (
        input  req_valid, req_addr, req_size, req_oper, req_priv, req_wdata,
        input  pmp_permission, mem_ready, trap_ack,
        output req_ready,
        output pmp_addr, pmp_size, pmp_oper, pmp_priv,
        output mem_valid, mem_addr, mem_size, mem_we, mem_wdata,
        output trap_valid, trap_cause, trap_tval,
        output fault_count
    );

    modport master (
        output req_valid, req_addr, req_size, req_oper, req_priv, req_wdata,
        output pmp_permission, mem_ready, trap_ack,
        input  req_ready,
        input  pmp_addr, pmp_size, pmp_oper, pmp_priv,
        input  mem_valid, mem_addr, mem_size, mem_we, mem_wdata,
        input  trap_valid, trap_cause, trap_tval,
        input  fault_count
    );

endinterface

// File: rtl/pmp_access_gate.sv
// Single-request gate in front of pmp: checks each core access, forwards
// permitted ones to memory and turns refused ones into a held access-fault trap.
module pmp_access_gate
    import pmp_access_gate_pkg::*;
#(
    parameter int CHECK_LAT = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    pmp_access_gate_if.slave bus
);

    localparam int                 TIMER_W    = (CHECK_LAT < 2) ? 1 : $clog2(CHECK_LAT + 1);
    localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(CHECK_LAT);

    gate_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    gate_req_t          req_q, req_d;
    logic               req_ready_q, req_ready_d;
    logic               mem_valid_q, mem_valid_d;
    logic               trap_valid_q, trap_valid_d;
    logic [3:0]         trap_cause_q, trap_cause_d;
    logic [31:0]        trap_tval_q, trap_tval_d;
    logic [CNT_W-1:0]   fault_count_q, fault_count_d;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        req_d         = req_q;
        req_ready_d   = req_ready_q;
        mem_valid_d   = mem_valid_q;
        trap_valid_d  = trap_valid_q;
        trap_cause_d  = trap_cause_q;
        trap_tval_d   = trap_tval_q;
        fault_count_d = fault_count_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d.addr  = bus.req_addr;
                    req_d.size  = bus.req_size;
                    req_d.oper  = mem_oper_e'(bus.req_oper);
                    req_d.priv  = bus.req_priv;
                    req_d.wdata = bus.req_wdata;
                    timer_d     = TIMER_INIT;
                    req_ready_d = 1'b0;
                    state_d     = CHECK;
                end
            end

            CHECK: begin
                // pmp inputs come straight from req_q, so they hold for the
                // whole wait; the verdict is taken once the timer has drained.
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (req_q.oper == OP_ILLEGAL || bus.pmp_permission != PERM_OK) begin
                    trap_valid_d = 1'b1;
                    trap_cause_d = fault_cause(req_q.oper);
                    trap_tval_d  = req_q.addr;
                    if (fault_count_q != '1)
                        fault_count_d = fault_count_q + CNT_W'(1);
                    state_d      = FAULT;
                end else begin
                    mem_valid_d = 1'b1;
                    state_d     = ISSUE;
                end
            end

            ISSUE: begin
                if (bus.mem_ready) begin
                    mem_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end

            FAULT: begin
                if (bus.trap_ack) begin
                    trap_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            req_q         <= '0;
            req_ready_q   <= 1'b1;
            mem_valid_q   <= 1'b0;
            trap_valid_q  <= 1'b0;
            trap_cause_q  <= '0;
            trap_tval_q   <= '0;
            fault_count_q <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            req_q         <= req_d;
            req_ready_q   <= req_ready_d;
            mem_valid_q   <= mem_valid_d;
            trap_valid_q  <= trap_valid_d;
            trap_cause_q  <= trap_cause_d;
            trap_tval_q   <= trap_tval_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign bus.req_ready   = req_ready_q;

    assign bus.pmp_addr    = req_q.addr;
    assign bus.pmp_size    = req_q.size;
    assign bus.pmp_oper    = req_q.oper;
    assign bus.pmp_priv    = req_q.priv;

    assign bus.mem_valid   = mem_valid_q;
    assign bus.mem_addr    = req_q.addr;
    assign bus.mem_size    = req_q.size;
    assign bus.mem_we      = (req_q.oper == OP_WRITE);
    assign bus.mem_wdata   = req_q.wdata;

    assign bus.trap_valid  = trap_valid_q;
    assign bus.trap_cause  = trap_cause_q;
    assign bus.trap_tval   = trap_tval_q;

    assign bus.fault_count = fault_count_q;

endmodule

// File: tb/tb_pmp_access_gate.sv
// Scoreboard bench: two gates (16-bit and 2-bit fault counters) share one
// stimulus stream and a single-region pmp model; a monitor checks every output cycle.
module tb_pmp_access_gate;
    import pmp_access_gate_pkg::*;

    localparam int          CHECK_LAT  = 1;
    localparam logic [31:0] REGION_TOP = 32'h1000;

    typedef struct {
        bit          trap;
        logic [3:0]  cause;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [1:0]  oper;
        logic [1:0]  priv;
        bit          we;
        logic [31:0] wdata;
        int          cnt16;
        int          cnt2;
        int          acc_cyc;
        bit          seen;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic perm_r, perm_w, perm_x;
    bit   manual;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   faults = 0;
    exp_t q[$];

    pmp_access_gate_if #(.CNT_W(16)) bus();
    pmp_access_gate_if #(.CNT_W(2))  sbus();

    pmp_access_gate #(.CHECK_LAT(CHECK_LAT), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    pmp_access_gate #(.CHECK_LAT(CHECK_LAT), .CNT_W(2)) dut_sat (
        .clock (clock),
        .reset (reset),
        .bus   (sbus)
    );

    // One TOR region [0, REGION_TOP) with R/W/X bits; M-mode bypasses it.
    function automatic logic [1:0] pmp_model(input logic [31:0] a, input logic [1:0] op,
                                             input logic [1:0] pv, input logic r,
                                             input logic w, input logic x);
        logic ok;
        ok = (pv == 2'd3) ||
             (a < REGION_TOP && ((op == 2'd0 && r) || (op == 2'd1 && w) || (op == 2'd2 && x)));
        if (ok) return 2'b11;
        return (a[3:2] == 2'b11) ? 2'b10 : {1'b0, a[2]};
    endfunction

    assign bus.pmp_permission  = pmp_model(bus.pmp_addr, bus.pmp_oper, bus.pmp_priv, perm_r, perm_w, perm_x);
    assign sbus.pmp_permission = pmp_model(sbus.pmp_addr, sbus.pmp_oper, sbus.pmp_priv, perm_r, perm_w, perm_x);
    assign sbus.req_valid = bus.req_valid;
    assign sbus.req_addr  = bus.req_addr;
    assign sbus.req_size  = bus.req_size;
    assign sbus.req_oper  = bus.req_oper;
    assign sbus.req_priv  = bus.req_priv;
    assign sbus.req_wdata = bus.req_wdata;
    assign sbus.mem_ready = bus.mem_ready;
    assign sbus.trap_ack  = bus.trap_ack;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: expected event did not occur as required", nm);
    endtask

    // Outcome of one access from the access rules alone.
    function automatic exp_t predict(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] op,
                                     input logic [1:0] pv, input logic [31:0] wd);
        exp_t e;
        e.addr = a; e.size = sz; e.oper = op; e.priv = pv; e.wdata = wd;
        e.we = (op == 2'd1); e.seen = 1'b0; e.acc_cyc = 0; e.cnt16 = 0; e.cnt2 = 0;
        if (op == 2'd3) begin
            e.trap = 1'b1; e.cause = 4'd2;
        end else if (pmp_model(a, op, pv, perm_r, perm_w, perm_x) == 2'b11) begin
            e.trap = 1'b0; e.cause = 4'd0;
        end else begin
            e.trap = 1'b1;
            e.cause = (op == 2'd2) ? 4'd1 : (op == 2'd0) ? 4'd5 : 4'd7;
        end
        return e;
    endfunction

    task automatic send(input logic [31:0] a, input logic [1:0] sz, input logic [1:0] op,
                        input logic [1:0] pv, input logic [31:0] wd, input bit hold);
        exp_t e;
        int   n = 0;
        bus.req_addr = a; bus.req_size = sz; bus.req_oper = op;
        bus.req_priv = pv; bus.req_wdata = wd; bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 200) begin
            @(posedge clock); #1; n++;
        end
        if (!bus.req_ready) begin
            flag("accept_timeout");
            bus.req_valid = 1'b0;
            return;
        end
        e = predict(a, sz, op, pv, wd);
        @(posedge clock); #1;
        e.acc_cyc = cyc;
        if (e.trap) faults++;
        e.cnt16 = (faults > 65535) ? 65535 : faults;
        e.cnt2  = (faults > 3) ? 3 : faults;
        q.push_back(e);
        if (!hold) bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clock); #1; n++;
        end
        if (q.size() != 0) begin
            flag("drain_timeout");
            q.delete();
        end
    endtask

    task automatic wait_sig(input bit want_trap);
        int n = 0;
        while (!(want_trap ? bus.trap_valid : bus.mem_valid) && n < 50) begin
            @(posedge clock); #1; n++;
        end
        if (!(want_trap ? bus.trap_valid : bus.mem_valid))
            flag(want_trap ? "trap_valid_timeout" : "mem_valid_timeout");
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready",   32'(bus.req_ready), 32'd1);
        chk("rst_mem_valid",   32'(bus.mem_valid), 32'd0);
        chk("rst_trap_valid",  32'(bus.trap_valid), 32'd0);
        chk("rst_trap_cause",  32'(bus.trap_cause), 32'd0);
        chk("rst_trap_tval",   bus.trap_tval, 32'd0);
        chk("rst_fault_count", 32'(bus.fault_count), 32'd0);
        chk("rst_fault_sat",   32'(sbus.fault_count), 32'd0);
        chk("rst_pmp_addr",    bus.pmp_addr, 32'd0);
        chk("rst_pmp_ctl",     32'({bus.pmp_size, bus.pmp_oper, bus.pmp_priv}), 32'd0);
        chk("rst_mem_addr",    bus.mem_addr, 32'd0);
        chk("rst_mem_ctl",     32'({bus.mem_size, bus.mem_we}), 32'd0);
        chk("rst_mem_wdata",   bus.mem_wdata, 32'd0);
    endtask

    task automatic reset_now();
        reset = 1'b0;
        #1;
        check_reset_vals();
        q.delete();
        faults = 0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        chk("req_ready_after_reset", 32'(bus.req_ready), 32'd1);
        chk("mem_valid_after_reset", 32'(bus.mem_valid), 32'd0);
        chk("trap_valid_after_reset", 32'(bus.trap_valid), 32'd0);
    endtask

    // Random memory/trap handshakes whenever no directed test owns them.
    initial begin
        forever begin
            @(posedge clock); #1;
            if (!manual) begin
                bus.mem_ready = ($urandom % 4) != 0;
                bus.trap_ack  = ($urandom % 3) == 0;
            end
        end
    end

    // Monitor: every cycle an output is presented, compare against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && (bus.mem_valid || bus.trap_valid)) begin
                if (q.size() == 0) begin
                    flag("unexpected_output");
                end else begin
                    e = q[0];
                    if (!e.seen) begin
                        chk("latency", 32'(cyc - e.acc_cyc), 32'(CHECK_LAT + 1));
                        q[0].seen = 1'b1;
                    end
                    chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
                    chk("pmp_addr", bus.pmp_addr, e.addr);
                    chk("pmp_ctl", 32'({bus.pmp_size, bus.pmp_oper, bus.pmp_priv}), 32'({e.size, e.oper, e.priv}));
                    chk("trap_valid", 32'(bus.trap_valid), 32'(e.trap));
                    chk("mem_valid", 32'(bus.mem_valid), 32'(!e.trap));
                    chk("sat_trap_valid", 32'(sbus.trap_valid), 32'(e.trap));
                    chk("sat_mem_valid", 32'(sbus.mem_valid), 32'(!e.trap));
                    chk("fault_count", 32'(bus.fault_count), 32'(e.cnt16));
                    chk("fault_count_sat", 32'(sbus.fault_count), 32'(e.cnt2));
                    if (e.trap) begin
                        chk("trap_cause", 32'(bus.trap_cause), 32'(e.cause));
                        chk("trap_tval", bus.trap_tval, e.addr);
                        chk("sat_trap_cause", 32'(sbus.trap_cause), 32'(e.cause));
                        if (bus.trap_ack) void'(q.pop_front());
                    end else begin
                        chk("mem_addr", bus.mem_addr, e.addr);
                        chk("mem_size", 32'(bus.mem_size), 32'(e.size));
                        chk("mem_we", 32'(bus.mem_we), 32'(e.we));
                        chk("mem_wdata", bus.mem_wdata, e.wdata);
                        if (bus.mem_ready) void'(q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        manual = 1'b1;
        bus.mem_ready = 1'b1; bus.trap_ack = 1'b0; bus.req_valid = 1'b0;
        bus.req_addr = '0; bus.req_size = '0; bus.req_oper = '0; bus.req_priv = '0; bus.req_wdata = '0;
        perm_r = 1'b1; perm_w = 1'b0; perm_x = 1'b0;

        #3 reset = 1'b0;
        #10;
        check_reset_vals();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // Allowed load.
        send(32'h40, 2'd3, 2'd0, 2'd0, 32'h0, 1'b0);
        wait_drain();

        // Denied store, trap held for 5 cycles before ack.
        send(32'h80, 2'd3, 2'd1, 2'd0, 32'h1234, 1'b0);
        wait_sig(1'b1);
        repeat (5) begin @(posedge clock); #1; end
        chk("trap_held", 32'(bus.trap_valid), 32'd1);
        bus.trap_ack = 1'b1;
        @(posedge clock); #1;
        bus.trap_ack = 1'b0;
        wait_drain();
        chk("fault_count_after_store", 32'(bus.fault_count), 32'd1);

        // Fetch from non-X region, then illegal oper in M-mode, back to back.
        bus.trap_ack = 1'b1;
        send(32'h100, 2'd3, 2'd2, 2'd0, 32'h0, 1'b1);
        send(32'h104, 2'd3, 2'd3, 2'd3, 32'h0, 1'b0);
        wait_drain();
        chk("fault_count_after_exec_ill", 32'(bus.fault_count), 32'd3);

        // Allowed store under 4 cycles of backpressure; stray trap_ack stays high.
        perm_w = 1'b1;
        bus.mem_ready = 1'b0;
        send(32'h200, 2'd3, 2'd1, 2'd1, 32'hDEADBEEF, 1'b0);
        wait_sig(1'b0);
        repeat (4) begin @(posedge clock); #1; end
        chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
        bus.mem_ready = 1'b1;
        @(posedge clock); #1;
        chk("single_transfer", 32'(bus.mem_valid), 32'd0);
        wait_drain();

        // Reset while in CHECK.
        send(32'h44, 2'd0, 2'd0, 2'd0, 32'h0, 1'b0);
        reset_now();

        // Reset while in FAULT.
        perm_w = 1'b0;
        bus.trap_ack = 1'b0;
        send(32'h88, 2'd1, 2'd1, 2'd0, 32'h5, 1'b0);
        wait_sig(1'b1);
        reset_now();

        // Randomized traffic; permissions reshuffled only while idle.
        manual = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i % 8 == 0) begin
                wait_drain();
                perm_r = 1'($urandom); perm_w = 1'($urandom); perm_x = 1'($urandom);
            end
            a  = ($urandom % 4 == 0) ? $urandom : ($urandom % REGION_TOP);
            sz = ($urandom % 3 == 2) ? 2'd3 : 2'($urandom % 2);
            send(a, sz, 2'($urandom), 2'($urandom), $urandom,
                 (i % 8 != 7) && ($urandom % 2 == 1));
        end
        bus.req_valid = 1'b0;
        wait_drain();
        manual = 1'b1;
        bus.trap_ack = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clock); #1;
        chk("final_fault_count", 32'(bus.fault_count), 32'(faults));
        chk("final_fault_sat", 32'(sbus.fault_count), 32'((faults > 3) ? 3 : faults));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
